// File: rtl/result_collector.sv
// Captures one falling-edge-strobed result byte per core, sums them,
// then streams the captured bytes out in core order.
module result_collector #(
  parameter int CORES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CORES*8-1:0] core_result,
  input  logic [CORES-1:0]   core_strobe,
  output logic [CORES-1:0]   done_mask,
  output logic               all_done,
  output logic [15:0]        total,
  output logic [15:0]        cycle_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_core,
  output logic [7:0]         out_data,
  output logic               out_last
);

  typedef enum logic [1:0] {
    COLLECT,
    STREAM,
    FINISHED
  } state_e;

  localparam logic [3:0] LAST = 4'(CORES - 1);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CORES-1:0]  strobe_q;
  logic [CORES-1:0]  mask_q, mask_d;
  logic              done_q, done_d;
  logic              armed_q;
  logic [15:0]       total_q, total_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        cap_q [CORES];
  logic [7:0]        cap_d [CORES];
  logic [CORES-1:0]  ev;
  logic [15:0]       sum;

  // armed_q masks the first cycle after reset so a strobe that was
  // already low during reset is not mistaken for a falling edge.
  always_comb begin
    ev = '0;
    if (state_q == COLLECT && armed_q) begin
      ev = strobe_q & ~core_strobe & ~mask_q;
    end
    sum   = '0;
    cap_d = cap_q;
    for (int k = 0; k < CORES; k++) begin
      if (ev[k]) begin
        sum      = sum + 16'(core_result[8*k +: 8]);
        cap_d[k] = core_result[8*k +: 8];
      end
    end
    mask_d  = mask_q | ev;
    total_d = total_q + sum;
    done_d  = &mask_d;
    cnt_d   = cnt_q;
    if (!done_q && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      COLLECT: begin
        if (done_q) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST) begin
            state_d = FINISHED;
          end
        end
      end
      default: begin
        state_d = FINISHED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      strobe_q <= '1;
      mask_q   <= '0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
      total_q  <= '0;
      cnt_q    <= '0;
      cap_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      strobe_q <= core_strobe;
      mask_q   <= mask_d;
      done_q   <= done_d;
      armed_q  <= 1'b1;
      total_q  <= total_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_core  = '0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == STREAM) begin
      out_valid = 1'b1;
      out_core  = idx_q;
      out_last  = (idx_q == LAST);
      for (int k = 0; k < CORES; k++) begin
        if (idx_q == 4'(k)) begin
          out_data = cap_q[k];
        end
      end
    end
  end

  assign done_mask   = mask_q;
  assign all_done    = done_q;
  assign total       = total_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: scoreboard queue of expected
// stream beats, popped by a monitor on each handshake.
module tb_result_collector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst;
  logic [31:0] a_res;
  logic [3:0]  a_stb;
  logic [3:0]  a_mask;
  logic        a_done;
  logic [15:0] a_total;
  logic [15:0] a_cnt;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_core;
  logic [7:0]  a_data;
  logic        a_last;

  logic         b_rst;
  logic [127:0] b_res;
  logic [15:0]  b_stb;
  logic [15:0]  b_mask;
  logic         b_done;
  logic [15:0]  b_total;
  logic [15:0]  b_cnt;
  logic         b_valid;
  logic         b_ready;
  logic [3:0]   b_core;
  logic [7:0]   b_data;
  logic         b_last;

  result_collector #(.CORES(4)) u_a (
    .clk(clk), .reset(a_rst),
    .core_result(a_res), .core_strobe(a_stb),
    .done_mask(a_mask), .all_done(a_done),
    .total(a_total), .cycle_count(a_cnt),
    .out_valid(a_valid), .out_ready(a_ready),
    .out_core(a_core), .out_data(a_data),
    .out_last(a_last)
  );

  result_collector #(.CORES(16)) u_b (
    .clk(clk), .reset(b_rst),
    .core_result(b_res), .core_strobe(b_stb),
    .done_mask(b_mask), .all_done(b_done),
    .total(b_total), .cycle_count(b_cnt),
    .out_valid(b_valid), .out_ready(b_ready),
    .out_core(b_core), .out_data(b_data),
    .out_last(b_last)
  );

  typedef struct {
    logic [3:0] core;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_valid && a_ready && !a_rst) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL beat: unexpected core %0d data %0h",
                 a_core, a_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat", {19'd0, a_core, a_data, a_last},
            {19'd0, e.core, e.data, e.last});
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst   = 1'b1;
    a_stb   = '1;
    a_ready = 1'b0;
    step(2);
    a_rst = 1'b0;
    step();
  endtask

  task automatic rep_a(input int k, input logic [7:0] v);
    a_res[8*k +: 8] = v;
    a_stb[k] = 1'b0;
    step();
    a_stb[k] = 1'b1;
    step();
  endtask

  task automatic push(input logic [3:0] c, input logic [7:0] d,
                      input logic l);
    beat_t b;
    b.core = c;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  initial begin
    a_rst = 1'b1; a_res = '0; a_stb = '1; a_ready = 1'b0;
    b_rst = 1'b1; b_res = '0; b_stb = '1; b_ready = 1'b0;

    // simultaneous report, 16 cores, sum 54
    step(2);
    chk("b reset total", 32'(b_total), 0);
    chk("b reset cnt", 32'(b_cnt), 0);
    chk("b reset valid", 32'(b_valid), 0);
    b_rst = 1'b0;
    step(2);
    chk("b total before", 32'(b_total), 0);
    for (int k = 0; k < 16; k++) begin
      b_res[8*k +: 8] = (k < 12) ? 8'd4 : ((k < 15) ? 8'd2 : 8'd0);
    end
    b_stb = '0;
    step();
    chk("b total", 32'(b_total), 54);
    chk("b mask", 32'(b_mask), 32'hFFFF);
    chk("b all_done", 32'(b_done), 1);
    chk("b cnt", 32'(b_cnt), 3);
    b_stb = '1;
    step();
    chk("b valid", 32'(b_valid), 1);
    chk("b beat0", {19'd0, b_core, b_data, b_last}, {19'd0, 4'd0, 8'd4, 1'b0});
    chk("b cnt frozen", 32'(b_cnt), 3);

    // basic accumulation + backpressured stream
    step();
    chk("a reset mask", 32'(a_mask), 0);
    chk("a reset data", 32'(a_data), 0);
    reset_a();
    rep_a(0, 8'd5);
    chk("a total c0", 32'(a_total), 5);
    chk("a mask c0", 32'(a_mask), 32'h1);
    rep_a(1, 8'd0);
    chk("a mask c1", 32'(a_mask), 32'h3);
    rep_a(2, 8'd7);
    chk("a done early", 32'(a_done), 0);
    a_res[31:24] = 8'd3;
    a_stb[3] = 1'b0;
    step();
    chk("a total", 32'(a_total), 15);
    chk("a mask", 32'(a_mask), 32'hF);
    chk("a all_done", 32'(a_done), 1);
    chk("a cnt", 32'(a_cnt), 8);
    chk("a valid collect", 32'(a_valid), 0);
    a_stb[3] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("a stall valid", 32'(a_valid), 1);
      chk("a stall beat", {19'd0, a_core, a_data, a_last},
          {19'd0, 4'd0, 8'd5, 1'b0});
    end
    push(4'd0, 8'd5, 1'b0);
    push(4'd1, 8'd0, 1'b0);
    push(4'd2, 8'd7, 1'b0);
    push(4'd3, 8'd3, 1'b1);
    a_ready = 1'b1;
    for (int s = 0; s < 20; s++) begin
      step();
      if (exp_q.size() == 0 && !a_valid) break;
    end
    chk("a drained", 32'(exp_q.size()), 0);
    chk("a fin valid", 32'(a_valid), 0);
    chk("a fin beat", {19'd0, a_core, a_data, a_last}, 0);
    rep_a(0, 8'd99);
    chk("a fin total", 32'(a_total), 15);
    chk("a fin cnt", 32'(a_cnt), 8);
    chk("a fin valid2", 32'(a_valid), 0);

    // duplicate report, then reset mid-stream at idx 2
    reset_a();
    rep_a(2, 8'd9);
    chk("dup total1", 32'(a_total), 9);
    rep_a(2, 8'd200);
    chk("dup total2", 32'(a_total), 9);
    chk("dup mask", 32'(a_mask), 32'h4);
    rep_a(0, 8'd1);
    rep_a(1, 8'd2);
    rep_a(3, 8'd3);
    chk("dup sum", 32'(a_total), 15);
    chk("dup valid", 32'(a_valid), 1);
    push(4'd0, 8'd1, 1'b0);
    push(4'd1, 8'd2, 1'b0);
    a_ready = 1'b1;
    step();
    step();
    a_ready = 1'b0;
    chk("mid drained", 32'(exp_q.size()), 0);
    chk("mid beat2", {19'd0, a_core, a_data, a_last},
        {19'd0, 4'd2, 8'd9, 1'b0});
    a_rst = 1'b1;
    a_stb[0] = 1'b0;
    a_res[7:0] = 8'd77;
    step();
    chk("rst valid", 32'(a_valid), 0);
    chk("rst beat", {19'd0, a_core, a_data, a_last}, 0);
    chk("rst mask", 32'(a_mask), 0);
    chk("rst total", 32'(a_total), 0);
    chk("rst cnt", 32'(a_cnt), 0);
    chk("rst done", 32'(a_done), 0);
    a_rst = 1'b0;
    step(2);
    chk("low strobe no event", 32'(a_mask), 0);
    a_stb[0] = 1'b1;
    step();
    rep_a(0, 8'd10);
    rep_a(1, 8'd20);
    rep_a(2, 8'd30);
    rep_a(3, 8'd40);
    chk("fresh total", 32'(a_total), 100);
    chk("fresh done", 32'(a_done), 1);

    // saturation with one core withheld
    reset_a();
    rep_a(0, 8'd1);
    rep_a(1, 8'd1);
    rep_a(2, 8'd1);
    step(65540);
    chk("sat cnt", 32'(a_cnt), 32'hFFFF);
    chk("sat done", 32'(a_done), 0);
    rep_a(3, 8'd1);
    chk("sat late done", 32'(a_done), 1);
    chk("sat late cnt", 32'(a_cnt), 32'hFFFF);
    chk("sat total", 32'(a_total), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
